educore_mem_bridge: RTL and testbench
=====================================

# educore_mem_bridge

Single-port memory bridge between the Educore core's separate instruction and data ports and one 64-bit-wide unified memory. It sits directly downstream of the core. Each core step, it serialises the data access and the instruction fetch onto the single memory port, using `core_clk_en` to hold the core until both results are registered. Byte lanes, store masks and alignment checks are handled here.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address bits used. Upper core address bits are ignored (wrap).

Ports:
- `clk`  in  1  single clock for the bridge, the core and the memory.
- `nreset`  in  1  reset, synchronous, active-low.
- `core_clk_en`  out  1  clock enable to Educore `clk_en`.
- `instruction_memory_en`  in  1  fetch request.
- `instruction_memory_a`  in  64  fetch byte address.
- `instruction_memory_v`  out  32  registered fetched instruction.
- `data_memory_a`  in  64  data byte address.
- `data_memory_s`  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- `data_memory_read`  in  1  load request.
- `data_memory_write`  in  1  store request.
- `data_memory_out_v`  in  64  store data, right-aligned.
- `data_memory_in_v`  out  64  registered load data, right-aligned.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  write, qualified by `mem_en`.
- `mem_wa`  out  ADDR_W-3  64-bit word address.
- `mem_be`  out  8  byte enables, bit i = byte lane i.
- `mem_wdata`  out  64  lane-shifted write data.
- `mem_rdata`  in  64  read data, valid exactly 1 cycle after an `mem_en`/!`mem_we` cycle.
- `align_err`  out  1  sticky misalignment flag. Cleared only by reset.

## Operation
- Request sampling: core ports are stable whenever `core_clk_en` = 0. The bridge uses them directly and does not latch them.
- FSM states: IDLE, DATA, INSTR, ICAP, DCAP, STEP.
  - IDLE: if `data_memory_read` | `data_memory_write` → DATA. Else if `instruction_memory_en` → INSTR. Else → STEP.
  - DATA: issue the data access. Next state is INSTR if fetch is requested; otherwise DCAP if load, otherwise STEP.
  - INSTR: issue the fetch. If the previous state was DATA with a load, capture `data_memory_in_v` from `mem_rdata` this cycle. → ICAP.
  - ICAP: capture `instruction_memory_v` = 32-bit half selected by a[2] (0 = [31:0], 1 = [63:32]). → STEP.
  - DCAP: capture load data. → STEP.
  - STEP: `core_clk_en` = 1 for exactly this cycle. → IDLE.
- Lane handling (lane = a[2:0]):
  - `mem_be` = ((1 << 2^s) − 1) << lane.
  - `mem_wdata` = `data_memory_out_v` << 8·lane.
  - Load data = `mem_rdata` >> 8·lane, with bytes above 2^s zeroed.
- `mem_wa` = a[ADDR_W-1:3].
- Alignment:
  - A data address not a multiple of 2^s, or a fetch address with a[1:0] ≠ 0, sets `align_err`.
  - The offending access is suppressed: `mem_en` stays 0, and a load or fetch captures 0.
  - The FSM sequence is unchanged, and the core still steps.
- Read and write both asserted: treat as write only. Load capture is skipped and `data_memory_in_v` holds its value.
- `mem_en` = 0 in IDLE, ICAP, DCAP and STEP.

## Timing
- Reset (`nreset` = 0 at a `clk` edge), effective from the next cycle:
  - state IDLE; `core_clk_en`, `mem_en`, `mem_we` and `align_err` = 0.
  - `instruction_memory_v` and `data_memory_in_v` = 0.
  - `mem_be`, `mem_wa` and `mem_wdata` = 0.
- Reset mid-sequence abandons the access. No `mem_en` is asserted in the cycle after a reset edge.
- Cycles per core step (IDLE through STEP inclusive):
  - fetch only: 4
  - load + fetch: 5
  - store + fetch: 5
  - load only: 4
  - store only: 3
  - nothing: 2
- Captured outputs are stable from the capture edge through the STEP edge. They change only at a capture.
- Any `clk` edge with `core_clk_en` = 1 is exactly one core step. The core never sees two consecutive enabled cycles.

## Structure
- Shared package `educore_mem_pkg`:
  - state enum.
  - size encodings `SZ_B`/`SZ_H`/`SZ_W`/`SZ_D`.
  - function `size_mask(s)` returning the 8-bit unshifted byte mask.
- One sub-module, `educore_lane_align`, purely combinational: given size, lane and data, it produces the byte enables, shifted write data, extracted read data and the misalignment flag. The FSM and registers stay in the top block.

## Test plan
- Fetch-only step, a=0x0104, memory word 0x20 = 0x11223344_AABBCCDD → `instruction_memory_v` = 0x11223344 at ICAP, `core_clk_en` pulses after 4 cycles.
- Store double 0x0123456789ABCDEF to 0x0100, then load byte from 0x0104 → `mem_be` = 0xFF, `data_memory_in_v` = 0x67.
- Store half 0xBEEF to 0x0106 → `mem_be` = 0xC0, `mem_wdata`[63:48] = 0xBEEF, and the other bytes of word 0x20 are unchanged.
- Load word from 0x0102 → `align_err` = 1 and stays 1, no `mem_en` in DATA, `data_memory_in_v` = 0, and the core still steps.
- Load + fetch in the same step → `mem_en` pulses in DATA and INSTR, both results correct, and `core_clk_en` occurs 5 cycles after IDLE.
- Assert `nreset` = 0 during DATA of a store → no write reaches memory after the reset edge, all outputs read 0, and the FSM restarts in IDLE.

Source files
------------

// File: rtl/educore_mem_pkg.sv
// Shared types for the Educore memory bridge: FSM state,
// access-size codes and the unshifted byte-mask helper.
package educore_mem_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    INSTR,
    ICAP,
    DCAP,
    STEP
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // One bit per byte touched by an access of size s, lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] s);
    logic [7:0] m;
    case (s)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/educore_mem_bridge_if.sv
// Unified 64-bit memory port. master = bridge, slave = memory.
// Signals: mem_en, mem_we, mem_wa, mem_be, mem_wdata, mem_rdata.
interface educore_mem_bridge_if
  import educore_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) ();

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-4:0] mem_wa;
  logic [7:0]        mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_en, mem_we, mem_wa, mem_be, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en, mem_we, mem_wa, mem_be, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/educore_lane_align.sv
// Combinational byte-lane steering for one data access.
// In: size, lane, wdata, rdata. Out: be, wdata_sh, rdata_ext, misaligned.
module educore_lane_align
  import educore_mem_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [2:0]      lane,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      be,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_ext,
  output logic            misaligned
);

  logic [7:0]      mask;
  logic [2:0]      amask;
  logic [XLEN-1:0] rsh;
  logic [XLEN-1:0] keep;

  always_comb begin
    mask     = size_mask(size);
    // Low address bits that must be zero: 0, 1, 3 or 7.
    amask    = {mask[7], mask[3], mask[1]};
    be       = mask << lane;
    wdata_sh = wdata << {lane, 3'b000};
    rsh      = rdata >> {lane, 3'b000};
    keep     = '0;
    for (int i = 0; i < 8; i++) begin
      keep[i*8 +: 8] = {8{mask[i]}};
    end
    rdata_ext  = rsh & keep;
    misaligned = (lane & amask) != 3'd0;
  end

endmodule

// File: rtl/educore_mem_bridge.sv
// Serialises Educore data access and fetch onto one 64-bit memory port.
// Ports: clk, nreset, core request/result ports, mem (master), align_err.
module educore_mem_bridge
  import educore_mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        nreset,
  output logic        core_clk_en,
  input  logic        instruction_memory_en,
  input  logic [63:0] instruction_memory_a,
  output logic [31:0] instruction_memory_v,
  input  logic [63:0] data_memory_a,
  input  logic [1:0]  data_memory_s,
  input  logic        data_memory_read,
  input  logic        data_memory_write,
  input  logic [63:0] data_memory_out_v,
  output logic [63:0] data_memory_in_v,
  educore_mem_bridge_if.master mem,
  output logic        align_err
);

  state_t state;
  state_t state_nx;

  logic        acc;
  logic        ld;
  logic        fetch;
  logic        i_mis;
  logic [7:0]  d_be;
  logic [63:0] d_wd;
  logic [63:0] d_rd;
  logic        d_mis;
  logic        unused_hi;

  assign acc   = data_memory_read | data_memory_write;
  // Read+write together is a store only.
  assign ld    = data_memory_read & ~data_memory_write;
  assign fetch = instruction_memory_en;
  assign i_mis = |instruction_memory_a[1:0];

  assign unused_hi = ^{data_memory_a[63:ADDR_W],
                       instruction_memory_a[63:ADDR_W]};

  educore_lane_align u_align (
    .size       (data_memory_s),
    .lane       (data_memory_a[2:0]),
    .wdata      (data_memory_out_v),
    .rdata      (mem.mem_rdata),
    .be         (d_be),
    .wdata_sh   (d_wd),
    .rdata_ext  (d_rd),
    .misaligned (d_mis)
  );

  always_ff @(posedge clk) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (acc)        state_nx = DATA;
        else if (fetch) state_nx = INSTR;
        else            state_nx = STEP;
      end
      DATA: begin
        if (fetch)   state_nx = INSTR;
        else if (ld) state_nx = DCAP;
        else         state_nx = STEP;
      end
      INSTR:   state_nx = ICAP;
      ICAP:    state_nx = STEP;
      DCAP:    state_nx = STEP;
      STEP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Port drive is gated by nreset so a reset landing mid-access
  // cannot commit a write at the reset edge.
  always_comb begin
    core_clk_en   = (state == STEP);
    mem.mem_en    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_wa    = '0;
    mem.mem_be    = '0;
    mem.mem_wdata = '0;
    if (nreset) begin
      if (state == DATA && !d_mis) begin
        mem.mem_en = 1'b1;
        mem.mem_we = data_memory_write;
        mem.mem_wa = data_memory_a[ADDR_W-1:3];
        mem.mem_be = d_be;
        if (data_memory_write) mem.mem_wdata = d_wd;
      end else if (state == INSTR && !i_mis) begin
        mem.mem_en = 1'b1;
        mem.mem_wa = instruction_memory_a[ADDR_W-1:3];
        mem.mem_be = instruction_memory_a[2] ? 8'hF0 : 8'h0F;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      instruction_memory_v <= '0;
      data_memory_in_v     <= '0;
      align_err            <= 1'b0;
    end else begin
      // Load data lands while the fetch is issued, or in DCAP.
      if ((state == INSTR && ld) || state == DCAP) begin
        data_memory_in_v <= d_mis ? 64'd0 : d_rd;
      end
      if (state == ICAP) begin
        if (i_mis)
          instruction_memory_v <= '0;
        else if (instruction_memory_a[2])
          instruction_memory_v <= mem.mem_rdata[63:32];
        else
          instruction_memory_v <= mem.mem_rdata[31:0];
      end
      if ((state == DATA && d_mis) || (state == INSTR && i_mis)) begin
        align_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_educore_mem_bridge.sv
// Directed bench for educore_mem_bridge with a byte-enabled
// synchronous memory model and hand-computed expectations.
module tb_educore_mem_bridge;

  logic        clk;
  logic        nreset;
  logic        core_clk_en;
  logic        instruction_memory_en;
  logic [63:0] instruction_memory_a;
  logic [31:0] instruction_memory_v;
  logic [63:0] data_memory_a;
  logic [1:0]  data_memory_s;
  logic        data_memory_read;
  logic        data_memory_write;
  logic [63:0] data_memory_out_v;
  logic [63:0] data_memory_in_v;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  logic [63:0] ram [0:8191];

  logic        en_tr [0:19];
  logic        we_tr [0:19];
  logic [7:0]  be_tr [0:19];
  logic [63:0] wd_tr [0:19];

  educore_mem_bridge_if #(.ADDR_W(16)) mem_if ();

  educore_mem_bridge #(.ADDR_W(16)) dut (
    .clk                   (clk),
    .nreset                (nreset),
    .core_clk_en           (core_clk_en),
    .instruction_memory_en (instruction_memory_en),
    .instruction_memory_a  (instruction_memory_a),
    .instruction_memory_v  (instruction_memory_v),
    .data_memory_a         (data_memory_a),
    .data_memory_s         (data_memory_s),
    .data_memory_read      (data_memory_read),
    .data_memory_write     (data_memory_write),
    .data_memory_out_v     (data_memory_out_v),
    .data_memory_in_v      (data_memory_in_v),
    .mem                   (mem_if.master),
    .align_err             (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_if.mem_en) begin
      if (mem_if.mem_we) begin
        for (int i = 0; i < 8; i++) begin
          if (mem_if.mem_be[i])
            ram[mem_if.mem_wa][i*8 +: 8] <= mem_if.mem_wdata[i*8 +: 8];
        end
      end else begin
        mem_if.mem_rdata <= ram[mem_if.mem_wa];
      end
    end
  end

  task automatic set_req(input logic f, input logic [63:0] fa,
                         input logic r, input logic w,
                         input logic [1:0] s, input logic [63:0] da,
                         input logic [63:0] dv);
    instruction_memory_en = f;
    instruction_memory_a  = fa;
    data_memory_read      = r;
    data_memory_write     = w;
    data_memory_s         = s;
    data_memory_a         = da;
    data_memory_out_v     = dv;
  endtask

  // Called at edge+1 in IDLE; returns cycles IDLE..STEP (99 on timeout)
  // and leaves time at edge+1 of the following IDLE.
  task automatic run_step(output int n);
    bit seen;
    seen = 0;
    n = 0;
    #1;
    while (n < 20) begin
      en_tr[n] = mem_if.mem_en;
      we_tr[n] = mem_if.mem_we;
      be_tr[n] = mem_if.mem_be;
      wd_tr[n] = mem_if.mem_wdata;
      n++;
      if (core_clk_en) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (!seen) n = 99;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    set_req(0, 64'd0, 0, 0, 2'd0, 64'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (core_clk_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_clk_en: got %b want 0", core_clk_en);
    end
    checks++;
    if ({mem_if.mem_en, mem_if.mem_we} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mem_en_we: got %b want 00",
               {mem_if.mem_en, mem_if.mem_we});
    end
    checks++;
    if (align_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_align: got %b want 0", align_err);
    end
    checks++;
    if (instruction_memory_v !== 32'd0 || data_memory_in_v !== 64'd0) begin
      errors++;
      $display("FAIL rst_capture: got %h %h want 0 0",
               instruction_memory_v, data_memory_in_v);
    end
    checks++;
    if (mem_if.mem_be !== 8'd0 || mem_if.mem_wa !== 13'd0 ||
        mem_if.mem_wdata !== 64'd0) begin
      errors++;
      $display("FAIL rst_bus: got be=%h wa=%h wd=%h want 0",
               mem_if.mem_be, mem_if.mem_wa, mem_if.mem_wdata);
    end
    nreset = 1'b1;
  endtask

  task automatic test_preload;
    int n;
    set_req(0, 64'd0, 0, 1, 2'd3, 64'h0100, 64'h11223344_AABBCCDD);
    run_step(n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL store_only_cycles: got %0d want 3", n);
    end
    checks++;
    if ({en_tr[1], we_tr[1], be_tr[1]} !== {2'b11, 8'hFF}) begin
      errors++;
      $display("FAIL preload_bus: got en=%b we=%b be=%h want 1 1 ff",
               en_tr[1], we_tr[1], be_tr[1]);
    end
    checks++;
    if (ram[32] !== 64'h11223344_AABBCCDD) begin
      errors++;
      $display("FAIL preload_ram: got %h want 11223344aabbccdd", ram[32]);
    end
  endtask

  task automatic test_fetch_only;
    int n;
    set_req(1, 64'h0104, 0, 0, 2'd0, 64'd0, 64'd0);
    run_step(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL fetch_cycles: got %0d want 4", n);
    end
    checks++;
    if ({en_tr[0], en_tr[1], we_tr[1], en_tr[2], en_tr[3]} !== 5'b01000) begin
      errors++;
      $display("FAIL fetch_en_trace: got %b%b%b%b we=%b want 0100 we=0",
               en_tr[0], en_tr[1], en_tr[2], en_tr[3], we_tr[1]);
    end
    checks++;
    if (instruction_memory_v !== 32'h11223344) begin
      errors++;
      $display("FAIL fetch_value: got %h want 11223344",
               instruction_memory_v);
    end
    checks++;
    if (core_clk_en !== 1'b0) begin
      errors++;
      $display("FAIL clk_en_single: got %b want 0", core_clk_en);
    end
  endtask

  task automatic test_store_load;
    int n;
    set_req(0, 64'd0, 0, 1, 2'd3, 64'h0100, 64'h01234567_89ABCDEF);
    run_step(n);
    checks++;
    if (be_tr[1] !== 8'hFF) begin
      errors++;
      $display("FAIL sd_be: got %h want ff", be_tr[1]);
    end
    set_req(0, 64'd0, 1, 0, 2'd0, 64'h0104, 64'd0);
    run_step(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL load_only_cycles: got %0d want 4", n);
    end
    checks++;
    if (be_tr[1] !== 8'h10 || en_tr[1] !== 1'b1 || we_tr[1] !== 1'b0) begin
      errors++;
      $display("FAIL lb_bus: got be=%h en=%b we=%b want 10 1 0",
               be_tr[1], en_tr[1], we_tr[1]);
    end
    checks++;
    if (data_memory_in_v !== 64'h67) begin
      errors++;
      $display("FAIL lb_value: got %h want 67", data_memory_in_v);
    end
  endtask

  task automatic test_store_half;
    int n;
    set_req(0, 64'd0, 0, 1, 2'd1, 64'h0106, 64'h0000_0000_0000_BEEF);
    run_step(n);
    checks++;
    if (be_tr[1] !== 8'hC0) begin
      errors++;
      $display("FAIL sh_be: got %h want c0", be_tr[1]);
    end
    checks++;
    if (wd_tr[1][63:48] !== 16'hBEEF) begin
      errors++;
      $display("FAIL sh_wdata: got %h want beef", wd_tr[1][63:48]);
    end
    checks++;
    if (ram[32] !== 64'hBEEF4567_89ABCDEF) begin
      errors++;
      $display("FAIL sh_ram: got %h want beef456789abcdef", ram[32]);
    end
  endtask

  task automatic test_misaligned;
    int n;
    checks++;
    if (align_err !== 1'b0) begin
      errors++;
      $display("FAIL align_before: got %b want 0", align_err);
    end
    set_req(0, 64'd0, 1, 0, 2'd2, 64'h0102, 64'd0);
    run_step(n);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL mis_cycles: got %0d want 4", n);
    end
    checks++;
    if (en_tr[1] !== 1'b0) begin
      errors++;
      $display("FAIL mis_mem_en: got %b want 0", en_tr[1]);
    end
    checks++;
    if (data_memory_in_v !== 64'd0 || align_err !== 1'b1) begin
      errors++;
      $display("FAIL mis_result: got data=%h err=%b want 0 1",
               data_memory_in_v, align_err);
    end
    set_req(0, 64'd0, 0, 0, 2'd0, 64'd0, 64'd0);
    run_step(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL nothing_cycles: got %0d want 2", n);
    end
    checks++;
    if (align_err !== 1'b1) begin
      errors++;
      $display("FAIL align_sticky: got %b want 1", align_err);
    end
  endtask

  task automatic test_load_fetch;
    int n;
    set_req(1, 64'h0100, 1, 0, 2'd3, 64'h0100, 64'd0);
    run_step(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL lf_cycles: got %0d want 5", n);
    end
    checks++;
    if ({en_tr[0], en_tr[1], en_tr[2], en_tr[3], en_tr[4]} !== 5'b01100) begin
      errors++;
      $display("FAIL lf_en_trace: got %b%b%b%b%b want 01100",
               en_tr[0], en_tr[1], en_tr[2], en_tr[3], en_tr[4]);
    end
    checks++;
    if (data_memory_in_v !== 64'hBEEF4567_89ABCDEF) begin
      errors++;
      $display("FAIL lf_data: got %h want beef456789abcdef",
               data_memory_in_v);
    end
    checks++;
    if (instruction_memory_v !== 32'h89ABCDEF) begin
      errors++;
      $display("FAIL lf_instr: got %h want 89abcdef", instruction_memory_v);
    end
  endtask

  task automatic test_store_fetch;
    int n;
    // Read and write both set: behaves as a store byte.
    set_req(1, 64'h0104, 1, 1, 2'd0, 64'h0101, 64'h0000_0000_0000_00AA);
    run_step(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL sf_cycles: got %0d want 5", n);
    end
    checks++;
    if (ram[32] !== 64'hBEEF4567_89ABAAEF) begin
      errors++;
      $display("FAIL sf_ram: got %h want beef456789abaaef", ram[32]);
    end
    checks++;
    if (data_memory_in_v !== 64'hBEEF4567_89ABCDEF) begin
      errors++;
      $display("FAIL rw_hold: got %h want beef456789abcdef",
               data_memory_in_v);
    end
    checks++;
    if (instruction_memory_v !== 32'hBEEF4567) begin
      errors++;
      $display("FAIL sf_instr: got %h want beef4567", instruction_memory_v);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    set_req(0, 64'd0, 0, 1, 2'd3, 64'h0108, 64'h55555555_55555555);
    run_step(n);
    set_req(0, 64'd0, 0, 1, 2'd3, 64'h0108, 64'hDEADBEEF_CAFEF00D);
    @(posedge clk);
    #1;
    checks++;
    if (mem_if.mem_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_data_en: got %b want 1", mem_if.mem_en);
    end
    nreset = 1'b0;
    #1;
    checks++;
    if (mem_if.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_gate_en: got %b want 0", mem_if.mem_en);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ram[33] !== 64'h55555555_55555555) begin
      errors++;
      $display("FAIL mid_ram: got %h want 5555555555555555", ram[33]);
    end
    checks++;
    if ({core_clk_en, mem_if.mem_en, mem_if.mem_we, align_err} !== 4'b0 ||
        instruction_memory_v !== 32'd0 || data_memory_in_v !== 64'd0 ||
        mem_if.mem_be !== 8'd0 || mem_if.mem_wdata !== 64'd0) begin
      errors++;
      $display("FAIL mid_outputs: got ce/en/we/err=%b iv=%h dv=%h be=%h",
               {core_clk_en, mem_if.mem_en, mem_if.mem_we, align_err},
               instruction_memory_v, data_memory_in_v, mem_if.mem_be);
    end
    set_req(0, 64'd0, 0, 0, 2'd0, 64'd0, 64'd0);
    nreset = 1'b1;
    run_step(n);
    checks++;
    if (n !== 2) begin
      errors++;
      $display("FAIL mid_restart: got %0d want 2", n);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_fetch_only();
    test_store_load();
    test_store_half();
    test_misaligned();
    test_load_fetch();
    test_store_fetch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
